// File: rtl/rans_byte_packer.sv
// rans_byte_packer: packs rANS encoder bytes little-endian into words and streams them out over AXI4-Stream
//   clk_i, rst_i (async, active-high)
//   valid_i/byte_i : encoder byte strobe, no backpressure
//   flush_i        : end-of-stream pulse, emits the partial (or null) word with tlast
//   m_axis_*       : FWFT word FIFO output {tdata, tkeep, tlast}
//   overflow_o     : sticky, a word was dropped on a full FIFO
//   byte_count_o   : bytes since last flush, present only with RANS_PACK_BYTE_COUNT_EN
module rans_byte_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 valid_i,
  input  logic [SYMBOL_WIDTH-1:0]              byte_i,
  input  logic                                 flush_i,
  output logic [WORD_WIDTH-1:0]                m_axis_tdata,
  output logic [WORD_WIDTH/SYMBOL_WIDTH-1:0]   m_axis_tkeep,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 overflow_o
`ifdef RANS_PACK_BYTE_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]               byte_count_o
`endif
);
  localparam int LANES = WORD_WIDTH / SYMBOL_WIDTH;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = WORD_WIDTH + LANES + 1;
  if (WORD_WIDTH % SYMBOL_WIDTH != 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || COUNT_WIDTH < 1) begin : g_bad_params
    $error("rans_byte_packer: illegal parameter combination");
  end
  logic [LW-1:0]         cnt;
  logic [LW:0]           cnt_n;
  logic [WORD_WIDTH-1:0] pack, pack_n;
  logic [LANES-1:0]      keep_n;
  logic                  complete, push, pop, wr_en, full, empty;
  logic [AW:0]           wr, rd;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  assign cnt_n    = {1'b0, cnt} + (LW+1)'(valid_i);
  assign complete = valid_i && cnt == LW'(LANES - 1);
  assign push     = complete || flush_i;
  // the packer register is cleared on every push, so lanes not yet written are already zero
  always_comb begin
    pack_n = pack;
    keep_n = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid_i && cnt == LW'(i)) pack_n[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = byte_i;
      keep_n[i] = (LW+1)'(i) < cnt_n;
    end
  end
  assign empty = wr == rd;
  assign full  = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
  assign pop   = !empty && m_axis_tready;
  // a pop frees the slot in the same cycle, so a push into a full FIFO is still taken then
  assign wr_en = push && (!full || pop);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt        <= '0;
      pack       <= '0;
      wr         <= '0;
      rd         <= '0;
      overflow_o <= 1'b0;
    end else begin
      cnt  <= push ? '0 : cnt_n[LW-1:0];
      pack <= push ? '0 : pack_n;
      if (wr_en) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      if (push && !wr_en) overflow_o <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr[AW-1:0]] <= {pack_n, keep_n, flush_i};
  end
  // outputs come only from registered state; empty forces them to zero
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = empty ? '0 : mem[rd[AW-1:0]];
  assign m_axis_tvalid = !empty;
`ifdef RANS_PACK_BYTE_COUNT_EN
  logic clr;
  // the flush cycle loads the final total; the following cycle restarts from zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_count_o <= '0;
      clr          <= 1'b0;
    end else begin
      byte_count_o <= (clr ? '0 : byte_count_o) + COUNT_WIDTH'(valid_i);
      clr          <= flush_i;
    end
  end
`endif
endmodule

// File: tb/tb_rans_byte_packer.sv
// tb_rans_byte_packer: directed and randomized checks of rans_byte_packer against a queue-based reference
module tb_rans_byte_packer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid = 1'b0, flush = 1'b0, tready = 1'b0;
  logic [7:0]  byte_in = '0;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, ovf;
  int          n_run = 0, n_fail = 0;
`ifdef RANS_PACK_BYTE_COUNT_EN
  logic [31:0] bcount;
`endif

  always #5 clk = ~clk;

  rans_byte_packer #(.SYMBOL_WIDTH(8), .WORD_WIDTH(32), .FIFO_DEPTH(16), .COUNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .byte_i(byte_in), .flush_i(flush),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .overflow_o(ovf)
`ifdef RANS_PACK_BYTE_COUNT_EN
    , .byte_count_o(bcount)
`endif
  );

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } word_t;

  task automatic cyc(input logic v, input logic [7:0] b, input logic f, input logic r);
    valid = v; byte_in = b; flush = f; tready = r;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_run++;
    if ({tvalid, tdata, tkeep, tlast, ovf} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b data=%h keep=%h last=%b ovf=%b, want all zero", tvalid, tdata, tkeep, tlast, ovf);
    end
`ifdef RANS_PACK_BYTE_COUNT_EN
    n_run++;
    if (bcount !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bcount); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_word;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
      if (i == 2) begin
        n_run++;
        if (tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_early: valid=%b want 0", tvalid); end
      end
    end
    n_run++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_word: valid=%b data=%h keep=%h last=%b want 1 44332211 f 0", tvalid, tdata, tkeep, tlast);
    end
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    n_run++;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: valid=%b want 0", tvalid); end
  endtask

  task automatic test_partial_flush;
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    cyc(1'b0, 8'h0, 1'b1, 1'b0);
    n_run++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL partial_w0: valid=%b data=%h keep=%h last=%b want 1 44332211 f 0", tvalid, tdata, tkeep, tlast);
    end
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    n_run++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h00006655, 4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL partial_w1: valid=%b data=%h keep=%h last=%b want 1 00006655 3 1", tvalid, tdata, tkeep, tlast);
    end
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    n_run++;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL partial_drain: valid=%b want 0", tvalid); end
  endtask

  task automatic test_same_cycle_flush;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
    cyc(1'b1, 8'h44, 1'b1, 1'b1);
    n_run++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL same_cycle: valid=%b data=%h keep=%h last=%b want 1 44332211 f 1", tvalid, tdata, tkeep, tlast);
    end
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    n_run++;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_null: valid=%b want 0 (no null word)", tvalid); end
  endtask

  task automatic test_empty_flush;
    word_t exp [3];
    exp[0] = '{32'h44332211, 4'hF, 1'b0};
    exp[1] = '{32'h88776655, 4'hF, 1'b0};
    exp[2] = '{32'h0, 4'h0, 1'b1};
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    cyc(1'b0, 8'h0, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) begin
      n_run++;
      if ({tvalid, tdata, tkeep, tlast} !== {1'b1, exp[w].d, exp[w].k, exp[w].l}) begin
        n_fail++;
        $display("FAIL empty_flush_w%0d: valid=%b data=%h keep=%h last=%b want 1 %h %h %b", w, tvalid, tdata, tkeep, tlast, exp[w].d, exp[w].k, exp[w].l);
      end
      cyc(1'b0, 8'h0, 1'b0, 1'b1);
    end
    n_run++;
    if ({tvalid, ovf} !== 2'b00) begin n_fail++; $display("FAIL empty_flush_end: valid=%b ovf=%b want 0 0", tvalid, ovf); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 68; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 63) begin
        n_run++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: ovf=%b want 0 after 16 words", ovf); end
      end
    end
    n_run++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: ovf=%b want 1 after 17 words", ovf); end
    for (int w = 0; w < 16; w++) begin
      logic [31:0] e;
      e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      n_run++;
      if ({tvalid, tdata, tkeep, tlast} !== {1'b1, e, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL ovf_drain_w%0d: valid=%b data=%h keep=%h last=%b want 1 %h f 0", w, tvalid, tdata, tkeep, tlast, e);
      end
      cyc(1'b0, 8'h0, 1'b0, 1'b1);
    end
    n_run++;
    if ({tvalid, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_after: valid=%b ovf=%b want 0 1", tvalid, ovf); end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 14; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    valid = 1'b0;
    n_run++;
    if (tvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_queued: valid=%b want 1", tvalid); end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if ({tvalid, tdata, tkeep, tlast, ovf} !== 39'd0) begin
      n_fail++;
      $display("FAIL midrst_zero: valid=%b data=%h keep=%h last=%b ovf=%b want all zero", tvalid, tdata, tkeep, tlast, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    n_run++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'hA3A2A1A0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_word: valid=%b data=%h keep=%h last=%b want 1 a3a2a1a0 f 0", tvalid, tdata, tkeep, tlast);
    end
`ifdef RANS_PACK_BYTE_COUNT_EN
    n_run++;
    if (bcount !== 32'd4) begin n_fail++; $display("FAIL count_pre_flush: got %0d want 4", bcount); end
`endif
    cyc(1'b0, 8'h0, 1'b1, 1'b0);
`ifdef RANS_PACK_BYTE_COUNT_EN
    n_run++;
    if (bcount !== 32'd4) begin n_fail++; $display("FAIL count_hold: got %0d want 4", bcount); end
`endif
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
`ifdef RANS_PACK_BYTE_COUNT_EN
    n_run++;
    if (bcount !== 32'd0) begin n_fail++; $display("FAIL count_clear: got %0d want 0", bcount); end
`endif
    n_run++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h0, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_null: valid=%b data=%h keep=%h last=%b want 1 0 0 1", tvalid, tdata, tkeep, tlast);
    end
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    n_run++;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_drain: valid=%b want 0", tvalid); end
  endtask

  task automatic test_random;
    word_t      q [$];
    logic [7:0] part [$];
    logic       m_ovf = 1'b0;
    int         errs = 0;
`ifdef RANS_PACK_BYTE_COUNT_EN
    logic [31:0] m_cnt = '0;
    logic        m_clr = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic v, f, r, pop, have, full_pre;
      logic [7:0] b;
      word_t w, e;
      v = $urandom_range(0, 9) < 7;
      b = 8'($urandom);
      f = $urandom_range(0, 19) == 0;
      r = (c >= 600 && c < 720) ? 1'b0 : $urandom_range(0, 3) != 0;
      cyc(v, b, f, r);
      pop = q.size() > 0 && r;
      full_pre = q.size() == 16;
      if (v) part.push_back(b);
      have = part.size() == 4 || f;
      w = '{32'h0, 4'h0, f};
      foreach (part[i]) begin
        w.d = w.d | (32'(part[i]) << (8 * i));
        w.k[i] = 1'b1;
      end
      if (have) part.delete();
      if (pop) void'(q.pop_front());
      if (have) begin
        if (full_pre && !pop) m_ovf = 1'b1;
        else q.push_back(w);
      end
      e = q.size() > 0 ? q[0] : '{32'h0, 4'h0, 1'b0};
      n_run++;
      if ({tvalid, tdata, tkeep, tlast, ovf} !== {q.size() > 0, e.d, e.k, e.l, m_ovf}) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random_c%0d: valid=%b data=%h keep=%h last=%b ovf=%b want %b %h %h %b %b",
                   c, tvalid, tdata, tkeep, tlast, ovf, q.size() > 0, e.d, e.k, e.l, m_ovf);
      end
`ifdef RANS_PACK_BYTE_COUNT_EN
      m_cnt = (m_clr ? 32'd0 : m_cnt) + 32'(v);
      m_clr = f;
      n_run++;
      if (bcount !== m_cnt) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL random_count_c%0d: got %0d want %0d", c, bcount, m_cnt);
      end
`endif
    end
    n_run++;
    if (m_ovf !== ovf) begin n_fail++; $display("FAIL random_ovf_final: got %b want %b", ovf, m_ovf); end
  endtask

  initial begin
    test_reset;
    test_basic_word;
    test_partial_flush;
    test_same_cycle_flush;
    test_empty_flush;
    test_overflow;
    test_reset_midstream;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
